// File: rtl/move_gather_arbiter_pkg.sv
// Shared constants, state encoding and move-classification helpers for the
// board-level move gatherer. Optional build macro: MGA_CAPTURE_FIRST_EN
// (see move_gather_arbiter.sv).
package move_gather_arbiter_pkg;

  localparam int NCOL  = 8;
  localparam int SLOTS = 8;
  localparam int MW    = 19;
  localparam int CNTW  = 8;
  localparam int WORDW = SLOTS * MW;   // one column FIFO word, 152 bits

  // Move layout: [18:12] flag, [11:6] from, [5:0] to.
  localparam int FLAG_LSB    = 12;
  localparam int FLG_INVALID = 6;     // flag bit index, i.e. move bit 18
  localparam int FLG_CAPTURE = 0;     // flag bit index, i.e. move bit 12

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_LAT  = 3'd2,
    ST_UNPK = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Invalid slots are either skips or the column's end-of-list marker.
  function automatic logic is_invalid(input logic [MW-1:0] m);
    return m[FLAG_LSB + FLG_INVALID];
  endfunction

  // End-of-list marker: invalid flag with from == to.
  function automatic logic is_end_marker(input logic [MW-1:0] m);
    return m[FLAG_LSB + FLG_INVALID] && (m[11:6] == m[5:0]);
  endfunction

endpackage

// File: rtl/move_gather_arbiter_rr_arb8.sv
// 8-request round-robin arbiter: grants the first request at or after ptr,
// wrapping around. Purely combinational; the caller owns the pointer.
module rr_arb8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] gnt,
  output logic [2:0] idx,
  output logic       any
);

  // Scan from ptr upward (mod 8) and take the first asserted request.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!any && req[ptr + 3'(k)]) begin
        any               = 1'b1;
        gnt[ptr + 3'(k)]  = 1'b1;
        idx               = ptr + 3'(k);
      end
    end
  end

endmodule

// File: rtl/move_gather_arbiter.sv
// Board-level move collector: round-robins over the column move FIFOs, pops
// one packed word per grant, unpacks it slot by slot and streams legal moves
// downstream. Build macro MGA_CAPTURE_FIRST_EN: columns whose head word has
// the capture flag set in slot 0 are served ahead of round-robin order.
//
// Output handshake: mv_valid/mv_data/mv_col are held stable while
// mv_valid=1 and mv_ready=0; a move transfers on a cycle where both are 1,
// and mv_valid never drops without a transfer except on reset.
module move_gather_arbiter
  import move_gather_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NCOL-1:0]         col_valid,
  output logic [NCOL-1:0]         col_rden,
  input  logic [NCOL*WORDW-1:0]   col_data,
  output logic                    mv_valid,
  input  logic                    mv_ready,
  output logic [MW-1:0]           mv_data,
  output logic [2:0]              mv_col,
  output logic [CNTW-1:0]         mv_count,
  output logic                    done
);

  state_t            state, state_nx;
  logic [NCOL-1:0]   fin;
  logic [2:0]        rr_ptr;
  logic [2:0]        gcol;
  logic [WORDW-1:0]  word;
  logic [2:0]        slot;
  logic [CNTW-1:0]   count;

  logic [MW-1:0]     cur;
  logic [NCOL-1:0]   eligible, arb_req, gnt;
  logic [2:0]        gidx;
  logic              gany;

  logic clear_pass, grant_load, word_load, slot_adv, word_end, mark_fin, accept;

  assign cur      = word[MW*slot +: MW];
  assign eligible = col_valid & ~fin;

`ifdef MGA_CAPTURE_FIRST_EN
  logic [NCOL-1:0] cap_req;

  // Peek slot 0 of each eligible column's presented word for the capture flag.
  always_comb begin
    cap_req = '0;
    for (int i = 0; i < NCOL; i++) begin
      cap_req[i] = eligible[i] & col_data[WORDW*i + FLAG_LSB + FLG_CAPTURE];
    end
  end

  assign arb_req = (|cap_req) ? cap_req : eligible;
`else
  assign arb_req = eligible;
`endif

  rr_arb8 u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // Next-state, read strobes, stream valid and register-update controls.
  always_comb begin
    state_nx   = state;
    col_rden   = '0;
    mv_valid   = 1'b0;
    clear_pass = 1'b0;
    grant_load = 1'b0;
    word_load  = 1'b0;
    slot_adv   = 1'b0;
    word_end   = 1'b0;
    mark_fin   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_pass = 1'b1;
          state_nx   = ST_ARB;
        end
      end
      ST_ARB: begin
        if (&fin) begin
          state_nx = ST_DONE;
        end else if (gany) begin
          col_rden   = gnt;
          grant_load = 1'b1;
          state_nx   = ST_LAT;
        end
      end
      ST_LAT: begin
        word_load = 1'b1;
        state_nx  = ST_UNPK;
      end
      ST_UNPK: begin
        if (is_end_marker(cur)) begin
          mark_fin = 1'b1;
          word_end = 1'b1;
          state_nx = ST_ARB;
        end else if (is_invalid(cur)) begin
          if (slot == 3'd7) begin
            word_end = 1'b1;
            state_nx = ST_ARB;
          end else begin
            slot_adv = 1'b1;
          end
        end else begin
          mv_valid = 1'b1;
          if (mv_ready) begin
            accept = 1'b1;
            if (slot == 3'd7) begin
              word_end = 1'b1;
              state_nx = ST_ARB;
            end else begin
              slot_adv = 1'b1;
            end
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, pass bookkeeping and the latched column word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      fin    <= '0;
      rr_ptr <= '0;
      gcol   <= '0;
      word   <= '0;
      slot   <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (clear_pass) begin
        fin   <= '0;
        count <= '0;
      end
      if (grant_load) gcol <= gidx;
      if (word_load) begin
        word <= col_data[WORDW*gcol +: WORDW];
        slot <= '0;
      end
      if (slot_adv) slot <= slot + 3'd1;
      if (mark_fin) fin[gcol] <= 1'b1;
      if (word_end) rr_ptr <= gcol + 3'd1;
      if (accept && (count != '1)) count <= count + 1'b1;
    end
  end

  assign mv_data  = cur;
  assign mv_col   = gcol;
  assign mv_count = count;
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_move_gather_arbiter.sv
// Bench for move_gather_arbiter: column FIFOs modelled as queues with a
// registered 1-cycle read port, a queue-based reference of the gather order,
// and a scoreboard of expected {column, move} pairs.
module tb_move_gather_arbiter;
  import move_gather_arbiter_pkg::*;

  localparam int INV_BIT = 18;
  localparam int CAP_BIT = 12;

  typedef logic [WORDW-1:0] word_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [NCOL-1:0]       col_valid = '0;
  logic [NCOL-1:0]       col_rden;
  logic [NCOL*WORDW-1:0] col_data = '0;
  logic                  mv_valid;
  logic                  mv_ready = 1'b0;
  logic [MW-1:0]         mv_data;
  logic [2:0]            mv_col;
  logic [CNTW-1:0]       mv_count;
  logic                  done;

  move_gather_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .col_valid (col_valid),
    .col_rden  (col_rden),
    .col_data  (col_data),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .mv_data   (mv_data),
    .mv_col    (mv_col),
    .mv_count  (mv_count),
    .done      (done)
  );

  // Clock
  always #5 clk = ~clk;

  // Column FIFOs seen by the DUT, and an independent copy for the model.
  word_t           dut_fifo[NCOL][$];
  word_t           mdl_fifo[NCOL][$];
  logic [MW+2:0]   exp_q[$];

  int checks = 0;
  int errors = 0;
  int rd_cnt[NCOL];
  int mdl_rd[NCOL];
  int acc_cnt;
  int mdl_count;
  int mdl_ptr = 0;
  int ready_mode = 2;   // 0: always ready, 1: random, 2: driven by the test
  int first_rd;

  // ---------------- move / word builders ----------------
  function automatic logic [MW-1:0] mk_move(input logic cap);
    logic [MW-1:0] m;
    m = MW'($urandom);
    m[INV_BIT] = 1'b0;
    m[CAP_BIT] = cap;
    return m;
  endfunction

  function automatic logic [MW-1:0] mk_skip();
    logic [MW-1:0] m;
    m = MW'($urandom);
    m[INV_BIT] = 1'b1;
    m[CAP_BIT] = 1'b0;
    if (m[11:6] == m[5:0]) m[5:0] = m[5:0] + 6'd1;
    return m;
  endfunction

  function automatic logic [MW-1:0] mk_end();
    logic [MW-1:0] m;
    m = MW'($urandom);
    m[INV_BIT] = 1'b1;
    m[CAP_BIT] = 1'b0;
    m[5:0] = m[11:6];
    return m;
  endfunction

  function automatic logic [MW-1:0] mk_rand_slot();
    if ($urandom_range(0, 9) < 7) return mk_move(1'($urandom_range(0, 1)));
    return mk_skip();
  endfunction

  // end_at < 0: no end marker; otherwise END at that slot and junk after it.
  function automatic word_t rand_word(input int end_at);
    word_t w;
    w = '0;
    for (int j = 0; j < SLOTS; j++) begin
      if (end_at >= 0 && j == end_at)     w[MW*j +: MW] = mk_end();
      else if (end_at >= 0 && j > end_at) w[MW*j +: MW] = MW'($urandom);
      else                                w[MW*j +: MW] = mk_rand_slot();
    end
    return w;
  endfunction

  function automatic word_t move_word();
    word_t w;
    for (int j = 0; j < SLOTS; j++) w[MW*j +: MW] = mk_move(1'($urandom_range(0, 1)));
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_word(input int c, input word_t w);
    dut_fifo[c].push_back(w);
    mdl_fifo[c].push_back(w);
  endtask

  task automatic refresh_cols(input logic [NCOL-1:0] pop);
    for (int c = 0; c < NCOL; c++) begin
      if (pop[c] && dut_fifo[c].size() > 0)
        col_data[WORDW*c +: WORDW] = dut_fifo[c].pop_front();
      else if (dut_fifo[c].size() > 0)
        col_data[WORDW*c +: WORDW] = dut_fifo[c][0];
      else
        col_data[WORDW*c +: WORDW] = '0;
      col_valid[c] = (dut_fifo[c].size() != 0);
    end
  endtask

  task automatic clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      dut_fifo[c].delete();
      mdl_fifo[c].delete();
    end
    refresh_cols('0);
  endtask

  // One clock: monitor at the falling edge, FIFO/ready update after the rise.
  task automatic step();
    logic [NCOL-1:0] rd_s;
    logic [MW+2:0]   e;
    @(negedge clk);
    rd_s = col_rden;
    if (rd_s != 0) begin
      checks++;
      if (!$onehot(rd_s)) begin
        errors++;
        $display("FAIL rden_onehot: got %b required one-hot", rd_s);
      end
      for (int c = 0; c < NCOL; c++) begin
        if (rd_s[c]) begin
          rd_cnt[c]++;
          if (first_rd < 0) first_rd = c;
        end
      end
    end
    if (mv_valid === 1'b1 && mv_ready === 1'b1) begin
      checks++;
      acc_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got col %0d move %h required no move", mv_col, mv_data);
      end else begin
        e = exp_q.pop_front();
        if ({mv_col, mv_data} !== e) begin
          errors++;
          $display("FAIL stream_move: got col %0d move %h required col %0d move %h",
                   mv_col, mv_data, e[MW+2:MW], e[MW-1:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    refresh_cols(rd_s);
    if (ready_mode == 0)      mv_ready = 1'b1;
    else if (ready_mode == 1) mv_ready = ($urandom_range(0, 9) < 7);
  endtask

  // ---------------- reference model ----------------
  // Replays a whole pass over the model FIFOs: pick a column by the
  // arbitration rule, pop its word, keep legal moves until END or slot 7.
  task automatic model_pass();
    logic [NCOL-1:0] fin;
    word_t           w;
    logic [MW-1:0]   m;
    int              g;
    int              n;
    int              c;
    fin = '0;
    n = 0;
    exp_q.delete();
    for (int i = 0; i < NCOL; i++) mdl_rd[i] = 0;
    while (fin != '1) begin
      g = -1;
`ifdef MGA_CAPTURE_FIRST_EN
      for (int k = 0; k < NCOL; k++) begin
        c = (mdl_ptr + k) % NCOL;
        if (g < 0 && !fin[c] && mdl_fifo[c].size() > 0 && mdl_fifo[c][0][CAP_BIT]) g = c;
      end
`endif
      for (int k = 0; k < NCOL; k++) begin
        c = (mdl_ptr + k) % NCOL;
        if (g < 0 && !fin[c] && mdl_fifo[c].size() > 0) g = c;
      end
      if (g < 0) begin
        $display("model: a column has no end marker queued");
        break;
      end
      w = mdl_fifo[g].pop_front();
      mdl_rd[g]++;
      for (int j = 0; j < SLOTS; j++) begin
        m = w[MW*j +: MW];
        if (m[INV_BIT] && m[11:6] == m[5:0]) begin
          fin[g] = 1'b1;
          break;
        end
        if (!m[INV_BIT]) begin
          exp_q.push_back({3'(g), m});
          n++;
        end
      end
      mdl_ptr = (g + 1) % NCOL;
    end
    mdl_count = (n > 255) ? 255 : n;
  endtask

  task automatic begin_pass();
    model_pass();
    for (int c = 0; c < NCOL; c++) rd_cnt[c] = 0;
    acc_cnt = 0;
    first_rd = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_after_start: got %b required 0", done);
    end
  endtask

  task automatic finish_pass(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got %b required 1 within %0d cycles", name, done, budget);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d moves missing required 0", name, exp_q.size());
    end
    checks++;
    if (mv_count !== CNTW'(mdl_count)) begin
      errors++;
      $display("FAIL %s_count: got %0d required %0d", name, mv_count, mdl_count);
    end
    for (int c = 0; c < NCOL; c++) begin
      checks++;
      if (rd_cnt[c] != mdl_rd[c]) begin
        errors++;
        $display("FAIL %s_reads_col%0d: got %0d required %0d", name, c, rd_cnt[c], mdl_rd[c]);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || mv_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_hold: got done %b valid %b required 1 0", name, done, mv_valid);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (col_rden !== '0 || mv_valid !== 1'b0 || mv_data !== '0 || mv_col !== '0 ||
        mv_count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rden %b valid %b data %h col %0d count %0d done %b required all 0",
               name, col_rden, mv_valid, mv_data, mv_col, mv_count, done);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mv_ready = 1'b0;
    ready_mode = 2;
    repeat (3) step();
    check_idle_outputs("reset_outputs");
    reset = 1'b0;
    mdl_ptr = 0;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_fifos();
    apply_reset();
    step();
    check_idle_outputs("idle_no_start");
  endtask

  task automatic test_all_columns();
    word_t w;
    clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      w = rand_word(3);
      for (int j = 0; j < 3; j++) w[MW*j +: MW] = mk_move(1'b0);
      push_word(c, w);
    end
    ready_mode = 0;
    begin_pass();
    finish_pass("all_columns", 400);
    checks++;
    if (mv_count !== 8'd24) begin
      errors++;
      $display("FAIL all_columns_24: got %0d required 24", mv_count);
    end
  endtask

  task automatic test_skip_end();
    word_t w;
    clear_fifos();
    w = '0;
    w[MW*0 +: MW] = mk_skip();
    w[MW*1 +: MW] = mk_move(1'b0);
    w[MW*2 +: MW] = mk_skip();
    w[MW*3 +: MW] = mk_move(1'b0);
    w[MW*4 +: MW] = mk_move(1'b0);
    w[MW*5 +: MW] = mk_end();
    w[MW*6 +: MW] = mk_move(1'b0);
    w[MW*7 +: MW] = mk_move(1'b0);
    for (int c = 0; c < NCOL; c++) begin
      if (c == 2) begin
        push_word(c, w);
        push_word(c, move_word());
      end else begin
        push_word(c, rand_word(0));
      end
    end
    ready_mode = 1;
    begin_pass();
    finish_pass("skip_end", 400);
    checks++;
    if (rd_cnt[2] != 1 || dut_fifo[2].size() != 1) begin
      errors++;
      $display("FAIL skip_end_no_reread: got reads %0d left %0d required 1 1",
               rd_cnt[2], dut_fifo[2].size());
    end
    checks++;
    if (mv_count !== 8'd3) begin
      errors++;
      $display("FAIL skip_end_count3: got %0d required 3", mv_count);
    end
  endtask

  task automatic test_stall();
    logic [MW-1:0]   d0;
    logic [2:0]      c0;
    logic [CNTW-1:0] n0;
    int              cyc;
    clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      if (c == 3) push_word(c, move_word());
      push_word(c, rand_word(0));
    end
    ready_mode = 2;
    mv_ready = 1'b1;
    begin_pass();
    cyc = 0;
    while (acc_cnt < 3 && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (acc_cnt < 3) begin
      errors++;
      $display("FAIL stall_reach: got %0d accepts required 3", acc_cnt);
    end
    mv_ready = 1'b0;
    d0 = mv_data;
    c0 = mv_col;
    n0 = mv_count;
    checks++;
    if (n0 !== 8'd3 || c0 !== 3'd3) begin
      errors++;
      $display("FAIL stall_entry: got count %0d col %0d required 3 3", n0, c0);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (mv_valid !== 1'b1 || mv_data !== d0 || mv_col !== c0 || mv_count !== n0) begin
        errors++;
        $display("FAIL stall_hold: got valid %b data %h col %0d count %0d required 1 %h %0d %0d",
                 mv_valid, mv_data, mv_col, mv_count, d0, c0, n0);
      end
    end
    ready_mode = 0;
    finish_pass("stall", 400);
  endtask

  task automatic test_multi_word();
    clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      if (c == 5) repeat (3) push_word(c, move_word());
      push_word(c, rand_word(0));
    end
    ready_mode = 1;
    begin_pass();
    finish_pass("multi_word", 800);
    checks++;
    if (rd_cnt[5] != 4 || mv_count !== 8'd24) begin
      errors++;
      $display("FAIL multi_word_col5: got reads %0d count %0d required 4 24", rd_cnt[5], mv_count);
    end
  endtask

  task automatic test_random_pass(input int npass);
    for (int p = 0; p < npass; p++) begin
      clear_fifos();
      for (int c = 0; c < NCOL; c++) begin
        repeat ($urandom_range(0, 2)) push_word(c, rand_word(-1));
        push_word(c, rand_word($urandom_range(0, SLOTS - 1)));
      end
      ready_mode = 1;
      begin_pass();
      finish_pass("random", 2000);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      if (c == 0) push_word(c, move_word());
      push_word(c, rand_word(0));
    end
    apply_reset();
    ready_mode = 2;
    mv_ready = 1'b1;
    begin_pass();
    cyc = 0;
    while (acc_cnt < 4 && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (acc_cnt < 4 || mv_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach: got accepts %0d valid %b required 4 1", acc_cnt, mv_valid);
    end
    mv_ready = 1'b0;
    reset = 1'b1;
    step();
    check_idle_outputs("reset_mid_outputs");
    reset = 1'b0;
    mdl_ptr = 0;
    exp_q.delete();
    step();
    check_idle_outputs("reset_mid_idle");
    test_random_pass(1);
  endtask

  task automatic test_saturate();
    clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      repeat (5) push_word(c, move_word());
      push_word(c, rand_word(0));
    end
    ready_mode = 0;
    begin_pass();
    finish_pass("saturate", 3000);
    checks++;
    if (mv_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate_255: got %0d required 255", mv_count);
    end
  endtask

`ifdef MGA_CAPTURE_FIRST_EN
  task automatic test_capture_first();
    word_t w;
    clear_fifos();
    for (int c = 0; c < NCOL; c++) begin
      if (c == 6 || c == 1) begin
        w = rand_word(1);
        w[MW*0 +: MW] = mk_move(c == 6);
        push_word(c, w);
      end else begin
        push_word(c, rand_word(0));
      end
    end
    apply_reset();
    ready_mode = 1;
    begin_pass();
    finish_pass("capture_first", 400);
    checks++;
    if (first_rd != 6) begin
      errors++;
      $display("FAIL capture_first_grant: got col %0d required 6", first_rd);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_all_columns();
    test_skip_end();
    test_stall();
    test_multi_word();
    test_random_pass(4);
    test_reset_mid();
    test_saturate();
`ifdef MGA_CAPTURE_FIRST_EN
    test_capture_first();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
